// File: rtl/cassette_writer_pkg.sv
// cas_writer_pkg: shared types and constants for the cassette record path.
// Optional build macro: CAS_WRITER_HEADER_EN (see cassette_writer.sv).
package cas_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2,
        GAP   = 2'd3
    } half_class_t;

    localparam int DEF_ADDR_W     = 18;
    localparam int DEF_GLITCH_MIN = 2000;
    localparam int DEF_SHORT_MAX  = 6667;
    localparam int DEF_GAP_MIN    = 13333;
    localparam int DEF_LEADER_MIN = 64;

    localparam int MARKER_LEN = 8;

    // CAS block marker written ahead of each data block.
    localparam logic [7:0] CAS_MARKER [MARKER_LEN] = '{
        8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74
    };

    function automatic logic [7:0] marker_byte(input logic [2:0] idx);
        return CAS_MARKER[idx];
    endfunction

endpackage

// File: rtl/cassette_writer_meas.sv
// cas_halfperiod_meas: synchronises the tap level, times each half-period
// in ce_i ticks and classifies it as SHORT, LONG or GAP one clock after the edge.
module cas_halfperiod_meas
    import cas_writer_pkg::*;
#(
    parameter int GLITCH_MIN = DEF_GLITCH_MIN,
    parameter int SHORT_MAX  = DEF_SHORT_MAX,
    parameter int GAP_MIN    = DEF_GAP_MIN
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        ce_i,
    input  logic        tap_i,
    output half_class_t half_o
);

    localparam int CNT_W = $clog2(GAP_MIN + 1);
    localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_MIN);
    localparam logic [CNT_W-1:0] SHORT_C  = CNT_W'(SHORT_MAX);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_MIN);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    half_class_t      half_r;
    half_class_t      half_next_s;
    logic             edge_s;

    assign edge_s = sync2_r ^ level_r;
    assign half_o = half_r;

    // Two-flop synchroniser for the asynchronous tap plus last-level register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
        end else begin
            sync1_r <= tap_i;
            sync2_r <= sync1_r;
            level_r <= sync2_r;
        end
    end

    // Classify an accepted edge, ignore glitches, saturate and flag GAP once.
    always_comb begin
        cnt_next_s  = cnt_r;
        half_next_s = NONE;
        if (edge_s && (cnt_r >= GLITCH_C)) begin
            cnt_next_s = '0;
            if (cnt_r <= SHORT_C) begin
                half_next_s = SHORT;
            end else begin
                half_next_s = LONG;
            end
        end else if (ce_i && (cnt_r < GAP_C)) begin
            cnt_next_s = cnt_r + CNT_W'(1);
            if (cnt_r == (GAP_C - CNT_W'(1))) begin
                half_next_s = GAP;
            end else begin
                half_next_s = NONE;
            end
        end else begin
            cnt_next_s  = cnt_r;
            half_next_s = NONE;
        end
    end

    // Half-period counter and registered classification.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_r  <= '0;
            half_r <= NONE;
        end else begin
            cnt_r  <= cnt_next_s;
            half_r <= half_next_s;
        end
    end

endmodule

// File: rtl/cassette_writer.sv
// cassette_writer: decodes the console cassette-out FSK into bytes and writes
// them sequentially into the CAS capture RAM through a req/ack port.
// Build macro CAS_WRITER_HEADER_EN: when defined, the 8-byte CAS block marker
// is written ahead of the decoded bytes on every SYNC to DATA transition.
module cassette_writer
    import cas_writer_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int GLITCH_MIN = DEF_GLITCH_MIN,
    parameter int SHORT_MAX  = DEF_SHORT_MAX,
    parameter int GAP_MIN    = DEF_GAP_MIN,
    parameter int LEADER_MIN = DEF_LEADER_MIN
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              ce_i,
    input  logic              tap_i,
    input  logic              motor_i,
    input  logic              rewind_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_data_o,
    output logic              ram_wr_o,
    input  logic              ram_ack_i,
    output logic [ADDR_W-1:0] byte_count_o,
    output logic [2:0]        status_o,
    output logic              active_o
);

    localparam int RUN_W = $clog2(LEADER_MIN + 1);
    localparam logic [RUN_W-1:0]  LEADER_C   = RUN_W'(LEADER_MIN);
    localparam logic [ADDR_W-1:0] LAST_C     = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]        HDR_DONE_C = 4'd8;

    half_class_t       half_s;
    wr_state_t         state_r;
    wr_state_t         state_next_s;
    logic              active_r;
    logic              active_next_s;

    logic [RUN_W-1:0]  run_r;
    logic              pend_long_r;

    logic [1:0]        nshort_r;
    logic [1:0]        nshort_next_s;
    logic              nlong_r;
    logic              nlong_next_s;
    logic              bit_done_s;
    logic              bit_val_s;
    logic              mix_err_s;
    logic              gap_mid_s;

    logic [3:0]        bit_cnt_r;
    logic [3:0]        bit_cnt_next_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_next_s;
    logic              byte_done_s;
    logic              stop_err_s;
    logic              ferr_set_s;

    logic              wr_pend_r;
    logic [7:0]        wr_data_r;
    logic [ADDR_W-1:0] byte_count_r;
    logic              full_r;
    logic              ovf_r;
    logic              ferr_r;
    logic [3:0]        hdr_idx_r;
    logic              hdr_busy_s;
    logic              hdr_start_s;

    cas_halfperiod_meas #(
        .GLITCH_MIN (GLITCH_MIN),
        .SHORT_MAX  (SHORT_MAX),
        .GAP_MIN    (GAP_MIN)
    ) u_meas (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .ce_i      (ce_i),
        .tap_i     (tap_i),
        .half_o    (half_s)
    );

    assign ram_addr_o   = byte_count_r;
    assign ram_data_o   = wr_data_r;
    assign ram_wr_o     = wr_pend_r;
    assign byte_count_o = byte_count_r;
    assign status_o     = {full_r, ovf_r, ferr_r};
    assign active_o     = active_r;
    assign hdr_busy_s   = (hdr_idx_r != HDR_DONE_C);
    assign ferr_set_s   = (state_r == DATA) && (mix_err_s || stop_err_s || gap_mid_s);

`ifdef CAS_WRITER_HEADER_EN
    assign hdr_start_s = (state_r == SYNC) && (state_next_s == DATA);
`else
    assign hdr_start_s = 1'b0;
`endif

    // Assemble classified halves into bits: four SHORT make a 1, two LONG a 0.
    always_comb begin
        nshort_next_s = nshort_r;
        nlong_next_s  = nlong_r;
        bit_done_s    = 1'b0;
        bit_val_s     = 1'b0;
        mix_err_s     = 1'b0;
        gap_mid_s     = 1'b0;
        case (half_s)
            SHORT: begin
                if (nlong_r) begin
                    mix_err_s     = 1'b1;
                    nshort_next_s = 2'd0;
                    nlong_next_s  = 1'b0;
                end else if (nshort_r == 2'd3) begin
                    bit_done_s    = 1'b1;
                    bit_val_s     = 1'b1;
                    nshort_next_s = 2'd0;
                end else begin
                    nshort_next_s = nshort_r + 2'd1;
                end
            end
            LONG: begin
                if (nshort_r != 2'd0) begin
                    mix_err_s     = 1'b1;
                    nshort_next_s = 2'd0;
                    nlong_next_s  = 1'b0;
                end else if (nlong_r) begin
                    bit_done_s   = 1'b1;
                    bit_val_s    = 1'b0;
                    nlong_next_s = 1'b0;
                end else begin
                    nlong_next_s = 1'b1;
                end
            end
            GAP: begin
                gap_mid_s     = nlong_r || (nshort_r != 2'd0);
                nshort_next_s = 2'd0;
                nlong_next_s  = 1'b0;
            end
            default: begin
                nshort_next_s = nshort_r;
                nlong_next_s  = nlong_r;
            end
        endcase
    end

    // Byte framing: 8 data bits LSB-first, stop bit, then idle marks or next start.
    always_comb begin
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        byte_done_s    = 1'b0;
        stop_err_s     = 1'b0;
        if ((state_r == DATA) && bit_done_s) begin
            if (bit_cnt_r < 4'd8) begin
                shift_next_s   = {bit_val_s, shift_r[7:1]};
                bit_cnt_next_s = bit_cnt_r + 4'd1;
            end else if (bit_cnt_r == 4'd8) begin
                bit_cnt_next_s = 4'd9;
                if (bit_val_s) begin
                    byte_done_s = 1'b1;
                end else begin
                    stop_err_s = 1'b1;
                end
            end else begin
                if (bit_val_s) begin
                    bit_cnt_next_s = 4'd9;
                end else begin
                    bit_cnt_next_s = 4'd0;
                end
            end
        end else begin
            bit_cnt_next_s = bit_cnt_r;
            shift_next_s   = shift_r;
        end
    end

    // Next state: rewind and motor-off dominate, then leader/start/data flow.
    always_comb begin
        state_next_s = state_r;
        if (rewind_i || !motor_i) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: state_next_s = SYNC;
                SYNC: begin
                    if ((half_s == LONG) && pend_long_r) begin
                        state_next_s = DATA;
                    end else begin
                        state_next_s = SYNC;
                    end
                end
                DATA: begin
                    if (mix_err_s || stop_err_s || (half_s == GAP)) begin
                        state_next_s = SYNC;
                    end else begin
                        state_next_s = DATA;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Output decode: active flag follows the upcoming state.
    always_comb begin
        active_next_s = (state_next_s == DATA);
    end

    // State and active-flag registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            active_r <= active_next_s;
        end
    end

    // Leader hunt: count SHORT halves, then arm on the first LONG of the start bit.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || (state_r != SYNC)) begin
            run_r       <= '0;
            pend_long_r <= 1'b0;
        end else begin
            case (half_s)
                SHORT: begin
                    pend_long_r <= 1'b0;
                    if (pend_long_r) begin
                        run_r <= RUN_W'(1);
                    end else if (run_r < LEADER_C) begin
                        run_r <= run_r + RUN_W'(1);
                    end
                end
                LONG: begin
                    if (pend_long_r) begin
                        pend_long_r <= 1'b0;
                        run_r       <= '0;
                    end else if (run_r >= LEADER_C) begin
                        pend_long_r <= 1'b1;
                    end else begin
                        run_r <= '0;
                    end
                end
                GAP: begin
                    run_r       <= '0;
                    pend_long_r <= 1'b0;
                end
                default: begin
                    run_r       <= run_r;
                    pend_long_r <= pend_long_r;
                end
            endcase
        end
    end

    // Bit and byte assembly registers, live only while staying in DATA.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            nshort_r  <= 2'd0;
            nlong_r   <= 1'b0;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
        end else if ((state_r == DATA) && (state_next_s == DATA)) begin
            nshort_r  <= nshort_next_s;
            nlong_r   <= nlong_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            shift_r   <= shift_next_s;
        end else begin
            nshort_r  <= 2'd0;
            nlong_r   <= 1'b0;
            bit_cnt_r <= 4'd0;
            shift_r   <= shift_r;
        end
    end

    // Write port: holding register, address counter, marker sequencer, sticky status.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_pend_r    <= 1'b0;
            wr_data_r    <= 8'h00;
            byte_count_r <= '0;
            full_r       <= 1'b0;
            ovf_r        <= 1'b0;
            ferr_r       <= 1'b0;
            hdr_idx_r    <= HDR_DONE_C;
        end else if (rewind_i) begin
            wr_pend_r    <= 1'b0;
            byte_count_r <= '0;
            full_r       <= 1'b0;
            ovf_r        <= 1'b0;
            ferr_r       <= 1'b0;
            hdr_idx_r    <= HDR_DONE_C;
        end else begin
            if (ferr_set_s) begin
                ferr_r <= 1'b1;
            end
            if (wr_pend_r && ram_ack_i) begin
                wr_pend_r    <= 1'b0;
                byte_count_r <= byte_count_r + ADDR_W'(1);
                if (byte_count_r == LAST_C) begin
                    full_r <= 1'b1;
                end
            end
            if (byte_done_s) begin
                if (!full_r) begin
                    if (wr_pend_r || hdr_busy_s) begin
                        ovf_r <= 1'b1;
                    end else begin
                        wr_data_r <= shift_r;
                        wr_pend_r <= 1'b1;
                    end
                end
            end else if (hdr_start_s) begin
                hdr_idx_r <= 4'd0;
            end else if (hdr_busy_s) begin
                if (full_r) begin
                    hdr_idx_r <= HDR_DONE_C;
                end else if (!wr_pend_r) begin
                    wr_data_r <= marker_byte(hdr_idx_r[2:0]);
                    wr_pend_r <= 1'b1;
                    hdr_idx_r <= hdr_idx_r + 4'd1;
                end
            end
        end
    end

endmodule
